// File: rtl/count_capture.sv
// Timestamp capture stage: extends an upstream CW-bit count with a wrap counter
// and queues {ext, cnt} snapshots in a show-ahead FIFO drained by valid/ready.
module count_capture #(
  parameter int CW    = 4,
  parameter int EW    = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CW-1:0]    cnt_in,
  input  logic             cap_req,
  input  logic             match_en,
  input  logic [CW-1:0]    match_val,
  input  logic             ovf_clr,
  output logic [EW+CW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW-1:0]    ext_cnt,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic             overflow,
  output logic [LW-1:0]    fifo_level
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_prev;
  logic [EW-1:0]    r_ext;
  logic             r_wrap;
  logic             r_match;
  logic             r_ovf;
  logic [EW+CW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic             w_wrap;
  logic             w_match;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic [EW-1:0]    w_ext_next;
  logic [EW+CW-1:0] w_snap;

  assign w_wrap     = (r_prev == {CW{1'b1}}) && (cnt_in == '0);
  assign w_match    = match_en && (cnt_in == match_val) && (cnt_in != r_prev);
  assign w_ext_next = r_ext + EW'(w_wrap);
  // Snapshot taken on the wrap cycle already carries the new epoch.
  assign w_snap     = {w_ext_next, cnt_in};

  assign w_push   = cap_req || w_match;
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = !w_empty && out_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_prev  <= '0;
      r_ext   <= '0;
      r_wrap  <= 1'b0;
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_prev  <= cnt_in;
      r_ext   <= w_ext_next;
      r_wrap  <= w_wrap;
      r_match <= w_match;
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      if (w_accept) begin
        r_mem[r_wptr] <= w_snap;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign out_data    = r_mem[r_rptr];
  assign out_valid   = !w_empty;
  assign ext_cnt     = r_ext;
  assign wrap_pulse  = r_wrap;
  assign match_pulse = r_match;
  assign overflow    = r_ovf;
  assign fifo_level  = r_level;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: wrap extension, capture, match and FIFO overflow.
module tb_count_capture;

  localparam int CW = 4;
  localparam int EW = 8;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             clr;
  logic [CW-1:0]    cnt_in;
  logic             cap_req;
  logic             match_en;
  logic [CW-1:0]    match_val;
  logic             ovf_clr;
  logic [EW+CW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [EW-1:0]    ext_cnt;
  logic             wrap_pulse;
  logic             match_pulse;
  logic             overflow;
  logic [LW-1:0]    fifo_level;

  int errors = 0;
  int checks = 0;

  count_capture #(.CW(CW), .EW(EW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .cnt_in(cnt_in), .cap_req(cap_req),
    .match_en(match_en), .match_val(match_val), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ext_cnt(ext_cnt), .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [CW-1:0] c);
    cnt_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_wrap();
    step(4'hF);
    step(4'h0);
  endtask

  initial begin
    clr = 1'b1; cnt_in = 4'd7; cap_req = 1'b1; match_en = 1'b0;
    match_val = '0; ovf_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ext",   32'(ext_cnt), 0);
    chk("rst_wrap",  32'(wrap_pulse), 0);
    chk("rst_match", 32'(match_pulse), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_level", 32'(fifo_level), 0);

    clr = 1'b0; cap_req = 1'b0;
    step(4'd0);
    chk("rel_wrap", 32'(wrap_pulse), 0);
    chk("rel_ext",  32'(ext_cnt), 0);

    // Count 0..15: no wrap yet; then 15->0 wraps once.
    for (int i = 0; i < 16; i++) step(4'(i));
    chk("pre_wrap", 32'(wrap_pulse), 0);
    step(4'd0);
    chk("wrap_pulse", 32'(wrap_pulse), 1);
    chk("wrap_ext1",  32'(ext_cnt), 1);
    step(4'd1);
    chk("wrap_single", 32'(wrap_pulse), 0);
    chk("wrap_ext1b",  32'(ext_cnt), 1);
    step(4'hF);
    step(4'hF);
    chk("held_ones", 32'(wrap_pulse), 0);
    for (int i = 0; i < 254; i++) do_wrap();
    chk("ext_255", 32'(ext_cnt), 255);
    do_wrap();
    chk("ext_roll", 32'(ext_cnt), 0);

    // Capture at cnt 5 with ext 2.
    do_wrap();
    do_wrap();
    cap_req = 1'b1;
    step(4'd5);
    cap_req = 1'b0;
    chk("cap_valid", 32'(out_valid), 1);
    chk("cap_data",  32'(out_data), 32'h025);
    chk("cap_level", 32'(fifo_level), 1);
    out_ready = 1'b1;
    step(4'd5);
    out_ready = 1'b0;
    chk("pop_valid", 32'(out_valid), 0);
    chk("pop_level", 32'(fifo_level), 0);

    // Capture on the wrap cycle with ext 3 takes the new epoch.
    do_wrap();
    chk("ext_3", 32'(ext_cnt), 3);
    step(4'hF);
    cap_req = 1'b1;
    step(4'd0);
    cap_req = 1'b0;
    chk("capwrap_data", 32'(out_data), 32'h040);
    chk("capwrap_wrap", 32'(wrap_pulse), 1);
    out_ready = 1'b1;
    step(4'd0);
    out_ready = 1'b0;
    chk("capwrap_pop", 32'(fifo_level), 0);

    // Match at 10, counter stalls there.
    match_en = 1'b1; match_val = 4'd10;
    step(4'd9);
    chk("match_none", 32'(match_pulse), 0);
    step(4'd10);
    chk("match_pulse", 32'(match_pulse), 1);
    chk("match_data",  32'(out_data), 32'h04A);
    step(4'd10);
    chk("match_stall", 32'(match_pulse), 0);
    step(4'd10);
    chk("match_once", 32'(fifo_level), 1);
    out_ready = 1'b1;
    step(4'd10);
    out_ready = 1'b0;
    chk("match_pop", 32'(fifo_level), 0);
    step(4'd11);
    cap_req = 1'b1;
    step(4'd10);
    cap_req = 1'b0;
    chk("capmatch_level", 32'(fifo_level), 1);
    chk("capmatch_pulse", 32'(match_pulse), 1);
    chk("capmatch_data",  32'(out_data), 32'h04A);
    out_ready = 1'b1;
    step(4'd10);
    out_ready = 1'b0;
    match_en = 1'b0;
    chk("capmatch_pop", 32'(fifo_level), 0);

    // Overflow: five captures into a 4-deep FIFO.
    cap_req = 1'b1;
    for (int i = 1; i <= 4; i++) step(4'(i));
    chk("full_level", 32'(fifo_level), 4);
    chk("full_noovf", 32'(overflow), 0);
    step(4'd5);
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_set",   32'(overflow), 1);
    chk("ovf_head",  32'(out_data), 32'h041);
    out_ready = 1'b1;
    step(4'd6);
    cap_req = 1'b0;
    chk("fullpp_level", 32'(fifo_level), 4);
    chk("fullpp_head",  32'(out_data), 32'h042);
    step(4'd6);
    chk("drain_3", 32'(out_data), 32'h043);
    step(4'd6);
    chk("drain_4", 32'(out_data), 32'h044);
    step(4'd6);
    chk("drain_6", 32'(out_data), 32'h046);
    chk("drain_lvl1", 32'(fifo_level), 1);
    step(4'd6);
    chk("drain_empty", 32'(out_valid), 0);
    cap_req = 1'b1;
    step(4'd7);
    cap_req = 1'b0;
    chk("emptypp_level", 32'(fifo_level), 1);
    chk("emptypp_data",  32'(out_data), 32'h047);
    step(4'd7);
    out_ready = 1'b0;
    chk("emptypp_pop", 32'(fifo_level), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step(4'd7);
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Drop with ovf_clr in the same cycle: set wins.
    cap_req = 1'b1;
    for (int i = 8; i < 12; i++) step(4'(i));
    ovf_clr = 1'b1;
    step(4'd12);
    ovf_clr = 1'b0;
    cap_req = 1'b0;
    chk("ovf_setwins", 32'(overflow), 1);

    // Asynchronous clear mid-operation.
    #2 clr = 1'b1;
    #1;
    chk("clr_level", 32'(fifo_level), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ovf",   32'(overflow), 0);
    chk("clr_ext",   32'(ext_cnt), 0);
    @(posedge clk);
    #1 clr = 1'b0;
    step(4'd0);
    chk("clr_after", 32'(fifo_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
